// File: rtl/clk_div_prog_pkg.sv
// Shared definitions for the programmable clock divider: FSM encoding and default sizing.
// Used by clk_div_prog and clk_div_ratio_reg.
package clk_div_prog_pkg;

  localparam int unsigned DEF_WIDTH      = 16;
  localparam int unsigned DEF_RESET_HALF = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_e;

endpackage

// File: rtl/clk_div_ratio_reg.sv
// Pending/active half-period registers: captures div_half loads, promotes the pending
// value to active when the divider allows it, and pulses load_ack on promotion.
module clk_div_ratio_reg
  import clk_div_prog_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned RESET_HALF = DEF_RESET_HALF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_half,
  input  logic             i_apply_ok,
  output logic [WIDTH-1:0] o_active_half,
  output logic             o_load_ack
);

  localparam logic [WIDTH-1:0] RESET_ACTIVE = (RESET_HALF == 0) ? WIDTH'(1) : WIDTH'(RESET_HALF);

  logic [WIDTH-1:0] r_pending_half;
  logic             r_pending_valid;
  logic [WIDTH-1:0] r_active_half;
  logic             r_load_ack;
  logic             w_apply;
  logic [WIDTH-1:0] w_half_clamped;

  assign w_apply        = r_pending_valid & i_apply_ok;
  assign w_half_clamped = (i_half == '0) ? WIDTH'(1) : i_half;

  // A load in the same cycle as an apply wins the pending slot for the next boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending_half  <= WIDTH'(1);
      r_pending_valid <= 1'b0;
      r_active_half   <= RESET_ACTIVE;
      r_load_ack      <= 1'b0;
    end else begin
      r_load_ack <= w_apply;
      if (w_apply) begin
        r_active_half <= r_pending_half;
      end
      if (i_load) begin
        r_pending_half  <= w_half_clamped;
        r_pending_valid <= 1'b1;
      end else if (w_apply) begin
        r_pending_valid <= 1'b0;
      end
    end
  end

  assign o_active_half = r_active_half;
  assign o_load_ack    = r_load_ack;

endmodule

// File: rtl/clk_div_prog.sv
// Programmable clock divider with glitch-free stop. Optional macro CLK_DIV_TICK_EN adds
// a one-cycle tick output coincident with each clk_out rising edge.
module clk_div_prog
  import clk_div_prog_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned RESET_HALF = DEF_RESET_HALF
) (
  input  logic             clk_100mhz,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] div_half,
  input  logic             div_load,
  output logic             clk_out,
  output logic             load_ack,
  output logic             running
`ifdef CLK_DIV_TICK_EN
  ,
  output logic             tick
`endif
);

  state_e           r_state;
  state_e           w_next_state;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic             r_clk_out;
  logic             w_clk_out_nxt;
  logic             r_running;
  logic [WIDTH-1:0] w_active_half;
  logic             w_boundary;
  logic             w_apply_ok;

  assign w_boundary = (r_state != ST_IDLE) && (r_cnt == (w_active_half - WIDTH'(1)));
  assign w_apply_ok = (r_state == ST_IDLE) || w_boundary;

  clk_div_ratio_reg #(
    .WIDTH      (WIDTH),
    .RESET_HALF (RESET_HALF)
  ) u_ratio (
    .clk           (clk_100mhz),
    .rst_n         (rst_n),
    .i_load        (div_load),
    .i_half        (div_half),
    .i_apply_ok    (w_apply_ok),
    .o_active_half (w_active_half),
    .o_load_ack    (load_ack)
  );

  // Next-state, counter and clock level; a stop request only ever ends at a phase boundary.
  always_comb begin
    w_next_state  = r_state;
    w_cnt_nxt     = r_cnt;
    w_clk_out_nxt = r_clk_out;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt     = '0;
        w_clk_out_nxt = 1'b0;
        if (en) begin
          w_next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_boundary) begin
          w_cnt_nxt = '0;
          if (!r_clk_out) begin
            if (en) begin
              w_clk_out_nxt = 1'b1;
            end else begin
              w_next_state = ST_IDLE;
            end
          end else begin
            w_clk_out_nxt = 1'b0;
            if (!en) begin
              w_next_state = ST_IDLE;
            end
          end
        end else begin
          w_cnt_nxt = r_cnt + WIDTH'(1);
          if (!en && r_clk_out) begin
            w_next_state = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (w_boundary) begin
          w_cnt_nxt     = '0;
          w_clk_out_nxt = 1'b0;
          w_next_state  = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + WIDTH'(1);
        end
      end
      default: begin
        w_cnt_nxt     = '0;
        w_clk_out_nxt = 1'b0;
        w_next_state  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_clk_out <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_cnt     <= w_cnt_nxt;
      r_clk_out <= w_clk_out_nxt;
      r_running <= (w_next_state != ST_IDLE);
    end
  end

`ifdef CLK_DIV_TICK_EN
  logic r_tick;
  logic w_rise;

  assign w_rise = ~r_clk_out & w_clk_out_nxt;

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_rise;
    end
  end

  assign tick = r_tick;
`endif

  assign clk_out = r_clk_out;
  assign running = r_running;

endmodule
